// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller: drives the instruction-memory request/response handshake,
// advances the PC register, and buffers {pc, inst, adel} entries for decode in a small FIFO.
module inst_fetch_ctrl #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcf,
  input  logic        adel,
  output logic        pc_en,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      pc_mem_q   [BUF_DEPTH];
  logic [31:0]      pc_mem_d   [BUF_DEPTH];
  logic [31:0]      inst_mem_q [BUF_DEPTH];
  logic [31:0]      inst_mem_d [BUF_DEPTH];
  logic             adel_mem_q [BUF_DEPTH];
  logic             adel_mem_d [BUF_DEPTH];

  logic        space;
  logic        fetch_ok;
  logic        accept;
  logic        adel_push;
  logic        data_push;
  logic        push;
  logic        pop;
  logic [31:0] push_pc;
  logic [31:0] push_inst;
  logic        push_adel;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a flush with a request in flight parks in DROP to swallow the stale response
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush) state_d = inst_data_ok ? S_REQ : S_DROP;
        else if (inst_data_ok) state_d = S_REQ;
      end
      S_DROP: begin
        if (inst_data_ok) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // Handshake outputs; space uses the pre-pop count so id_ready never reaches inst_req
  always_comb begin
    space     = (count_q < DEPTH_C);
    fetch_ok  = rst_n && !flush && space && (state_q == S_REQ);
    inst_req  = fetch_ok && !adel;
    inst_addr = pcf;
    accept    = inst_req && inst_addr_ok;
    adel_push = fetch_ok && adel;
    pc_en     = rst_n && (flush || accept || adel_push);
  end

  always_comb begin
    data_push = (state_q == S_WAIT) && inst_data_ok && !flush;
    push      = adel_push || data_push;
    pop       = id_valid && id_ready && !flush;
    push_pc   = adel_push ? pcf : req_pc_q;
    push_inst = adel_push ? 32'h0 : inst_rdata;
    push_adel = adel_push;
  end

  always_comb begin
    req_pc_d   = accept ? pcf : req_pc_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    adel_mem_d = adel_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = push_pc;
        inst_mem_d[wr_ptr_q] = push_inst;
        adel_mem_d[wr_ptr_q] = push_adel;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc_q <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
        adel_mem_q[i] <= 1'b0;
      end
    end else begin
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
      adel_mem_q <= adel_mem_d;
    end
  end

  always_comb begin
    id_valid = (count_q != '0);
    id_pc    = pc_mem_q[rd_ptr_q];
    id_inst  = inst_mem_q[rd_ptr_q];
    id_adel  = adel_mem_q[rd_ptr_q];
  end

endmodule
